// File: rtl/udma_lin_ch_alloc.sv
// udma_lin_ch_alloc: runtime allocator for the uDMA TX/RX linear channel pools.
// Ports: clk_i/rstn_i clock and async active-low reset; req_* allocation request
// (valid/ready, pool select, peripheral ID); gnt_* grant response (valid/ready,
// ok flag, channel ID); rel_* single-cycle release strobe with rel_err_o pulse on
// illegal release; tx/rx_busy_o allocated bitmaps, tx/rx_owner_o packed owner IDs,
// tx/rx_free_cnt_o free channel counts.
// Optional: define UDMA_CH_ALLOC_STICKY_EN to re-grant a peripheral's last released
// channel in preference to the lowest free one.
module udma_lin_ch_alloc #(
  parameter int N_TX_CH   = 8,
  parameter int N_RX_CH   = 8,
  parameter int N_PERIPHS = 16,
  parameter int CH_W      = $clog2(((N_TX_CH > N_RX_CH) ? N_TX_CH : N_RX_CH) > 2 ?
                                   ((N_TX_CH > N_RX_CH) ? N_TX_CH : N_RX_CH) : 2),
  parameter int PER_W     = $clog2(N_PERIPHS)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_dir_i,
  input  logic [PER_W-1:0]         req_per_id_i,
  output logic                     gnt_valid_o,
  input  logic                     gnt_ready_i,
  output logic                     gnt_ok_o,
  output logic [CH_W-1:0]          gnt_ch_id_o,
  input  logic                     rel_valid_i,
  input  logic                     rel_dir_i,
  input  logic [CH_W-1:0]          rel_ch_id_i,
  output logic                     rel_err_o,
  output logic [N_TX_CH-1:0]       tx_busy_o,
  output logic [N_RX_CH-1:0]       rx_busy_o,
  output logic [N_TX_CH*PER_W-1:0] tx_owner_o,
  output logic [N_RX_CH*PER_W-1:0] rx_owner_o,
  output logic [CH_W:0]            tx_free_cnt_o,
  output logic [CH_W:0]            rx_free_cnt_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [PER_W-1:0] tx_own [N_TX_CH];
  logic [PER_W-1:0] rx_own [N_RX_CH];
  logic tx_any, rx_any, tx_pick_ok, rx_pick_ok;
  logic [CH_W-1:0] tx_lo, rx_lo, tx_pick, rx_pick;
  logic acc, tx_alloc, rx_alloc, tx_rel, rx_rel;
  assign req_ready_o = state == IDLE;
  assign gnt_valid_o = state == RESP;
  for (genvar i = 0; i < N_TX_CH; i++) begin : g_tx
    assign tx_owner_o[i*PER_W +: PER_W] = tx_own[i];
  end
  for (genvar i = 0; i < N_RX_CH; i++) begin : g_rx
    assign rx_owner_o[i*PER_W +: PER_W] = rx_own[i];
  end
  // Downward scan so the last hit is the lowest free index; uses registered busy,
  // so a channel released this cycle is not yet eligible.
  always_comb begin
    tx_any = 1'b0;
    tx_lo  = '0;
    rx_any = 1'b0;
    rx_lo  = '0;
    for (int i = N_TX_CH-1; i >= 0; i--) if (!tx_busy_o[i]) begin tx_any = 1'b1; tx_lo = CH_W'(i); end
    for (int i = N_RX_CH-1; i >= 0; i--) if (!rx_busy_o[i]) begin rx_any = 1'b1; rx_lo = CH_W'(i); end
  end
`ifdef UDMA_CH_ALLOC_STICKY_EN
  logic [CH_W-1:0] tx_last [N_PERIPHS];
  logic [CH_W-1:0] rx_last [N_PERIPHS];
  logic [N_PERIPHS-1:0] tx_last_vld, rx_last_vld;
  logic tx_stk, rx_stk;
  // A stored last channel is always in range: it is only written on legal release.
  assign tx_stk     = tx_last_vld[req_per_id_i] && !tx_busy_o[tx_last[req_per_id_i]];
  assign rx_stk     = rx_last_vld[req_per_id_i] && !rx_busy_o[rx_last[req_per_id_i]];
  assign tx_pick_ok = tx_stk || tx_any;
  assign rx_pick_ok = rx_stk || rx_any;
  assign tx_pick    = tx_stk ? tx_last[req_per_id_i] : tx_lo;
  assign rx_pick    = rx_stk ? rx_last[req_per_id_i] : rx_lo;
`else
  assign tx_pick_ok = tx_any;
  assign rx_pick_ok = rx_any;
  assign tx_pick    = tx_lo;
  assign rx_pick    = rx_lo;
`endif
  assign acc      = state == IDLE && req_valid_i;
  assign tx_alloc = acc && !req_dir_i && tx_pick_ok;
  assign rx_alloc = acc && req_dir_i && rx_pick_ok;
  assign tx_rel   = rel_valid_i && !rel_dir_i && 32'(rel_ch_id_i) < N_TX_CH && tx_busy_o[rel_ch_id_i];
  assign rx_rel   = rel_valid_i && rel_dir_i && 32'(rel_ch_id_i) < N_RX_CH && rx_busy_o[rel_ch_id_i];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state         <= IDLE;
      gnt_ok_o      <= 1'b0;
      gnt_ch_id_o   <= '0;
      rel_err_o     <= 1'b0;
      tx_busy_o     <= '0;
      rx_busy_o     <= '0;
      tx_free_cnt_o <= (CH_W+1)'(N_TX_CH);
      rx_free_cnt_o <= (CH_W+1)'(N_RX_CH);
      for (int i = 0; i < N_TX_CH; i++) tx_own[i] <= '0;
      for (int i = 0; i < N_RX_CH; i++) rx_own[i] <= '0;
`ifdef UDMA_CH_ALLOC_STICKY_EN
      tx_last_vld <= '0;
      rx_last_vld <= '0;
      for (int i = 0; i < N_PERIPHS; i++) begin tx_last[i] <= '0; rx_last[i] <= '0; end
`endif
    end else begin
      rel_err_o     <= rel_valid_i && !tx_rel && !rx_rel;
      tx_busy_o     <= (tx_busy_o & ~(tx_rel ? N_TX_CH'(1) << rel_ch_id_i : '0)) | (tx_alloc ? N_TX_CH'(1) << tx_pick : '0);
      rx_busy_o     <= (rx_busy_o & ~(rx_rel ? N_RX_CH'(1) << rel_ch_id_i : '0)) | (rx_alloc ? N_RX_CH'(1) << rx_pick : '0);
      tx_free_cnt_o <= tx_free_cnt_o + (CH_W+1)'(tx_rel) - (CH_W+1)'(tx_alloc);
      rx_free_cnt_o <= rx_free_cnt_o + (CH_W+1)'(rx_rel) - (CH_W+1)'(rx_alloc);
      if (tx_alloc) tx_own[tx_pick] <= req_per_id_i;
      if (rx_alloc) rx_own[rx_pick] <= req_per_id_i;
`ifdef UDMA_CH_ALLOC_STICKY_EN
      if (tx_rel) begin tx_last[tx_own[rel_ch_id_i]] <= rel_ch_id_i; tx_last_vld[tx_own[rel_ch_id_i]] <= 1'b1; end
      if (rx_rel) begin rx_last[rx_own[rel_ch_id_i]] <= rel_ch_id_i; rx_last_vld[rx_own[rel_ch_id_i]] <= 1'b1; end
`endif
      if (acc) begin
        state       <= RESP;
        gnt_ok_o    <= req_dir_i ? rx_pick_ok : tx_pick_ok;
        gnt_ch_id_o <= req_dir_i ? (rx_pick_ok ? rx_pick : '0) : (tx_pick_ok ? tx_pick : '0);
      end else if (state == RESP && gnt_ready_i) state <= IDLE;
    end
endmodule

// File: tb/tb_udma_lin_ch_alloc.sv
// tb_udma_lin_ch_alloc: directed + random bench for udma_lin_ch_alloc against a pool model.
module tb_udma_lin_ch_alloc;
  localparam int NT = 12, NR = 8, NP = 16, CW = 4, PW = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_dir = 1'b0, gnt_ready = 1'b0;
  logic rel_valid = 1'b0, rel_dir = 1'b0;
  logic [PW-1:0] req_per = '0;
  logic [CW-1:0] rel_ch = '0;
  logic req_ready, gnt_valid, gnt_ok, rel_err;
  logic [CW-1:0] gnt_ch;
  logic [NT-1:0] tx_busy;
  logic [NR-1:0] rx_busy;
  logic [NT*PW-1:0] tx_owner;
  logic [NR*PW-1:0] rx_owner;
  logic [CW:0] tx_free, rx_free;
  int checks = 0, passed = 0;
  bit m_busy [2][16];
  int m_own  [2][16];
  int m_last [2][NP];
  bit m_lv   [2][NP];
  always #5 clk = ~clk;
  udma_lin_ch_alloc #(.N_TX_CH(NT), .N_RX_CH(NR), .N_PERIPHS(NP)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dir_i(req_dir), .req_per_id_i(req_per), .gnt_valid_o(gnt_valid),
    .gnt_ready_i(gnt_ready), .gnt_ok_o(gnt_ok), .gnt_ch_id_o(gnt_ch),
    .rel_valid_i(rel_valid), .rel_dir_i(rel_dir), .rel_ch_id_i(rel_ch), .rel_err_o(rel_err),
    .tx_busy_o(tx_busy), .rx_busy_o(rx_busy), .tx_owner_o(tx_owner), .rx_owner_o(rx_owner),
    .tx_free_cnt_o(tx_free), .rx_free_cnt_o(rx_free)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic int psz(input bit d);
    return d ? NR : NT;
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin m_busy[d][i] = 0; m_own[d][i] = 0; end
      for (int p = 0; p < NP; p++) begin m_lv[d][p] = 0; m_last[d][p] = 0; end
    end
  endtask
  task automatic model_pick(input bit d, input int per, output bit ok, output int ch);
    int fr[$];
    ok = 0;
    ch = 0;
    for (int i = 0; i < psz(d); i++) if (!m_busy[d][i]) fr.push_back(i);
    if (fr.size() > 0) begin ok = 1; ch = fr[0]; end
`ifdef UDMA_CH_ALLOC_STICKY_EN
    if (m_lv[d][per] && !m_busy[d][m_last[d][per]]) begin ok = 1; ch = m_last[d][per]; end
`endif
  endtask
  task automatic model_rel(input bit d, input int ch, output bit legal);
    legal = ch < psz(d) && m_busy[d][ch];
    if (legal) begin
      m_busy[d][ch] = 0;
      m_last[d][m_own[d][ch]] = ch;
      m_lv[d][m_own[d][ch]] = 1;
    end
  endtask
  task automatic check_state();
    logic [63:0] eb_t, eb_r, eo_t, eo_r;
    int nt, nr;
    eb_t = '0; eb_r = '0; eo_t = '0; eo_r = '0; nt = NT; nr = NR;
    for (int i = 0; i < NT; i++) begin
      eb_t[i] = m_busy[0][i];
      eo_t[i*PW +: PW] = PW'(m_own[0][i]);
      nt -= int'(m_busy[0][i]);
    end
    for (int i = 0; i < NR; i++) begin
      eb_r[i] = m_busy[1][i];
      eo_r[i*PW +: PW] = PW'(m_own[1][i]);
      nr -= int'(m_busy[1][i]);
    end
    chk("tx_busy", 64'(tx_busy), eb_t);
    chk("rx_busy", 64'(rx_busy), eb_r);
    chk("tx_owner", 64'(tx_owner), eo_t);
    chk("rx_owner", 64'(rx_owner), eo_r);
    chk("tx_free", 64'(tx_free), 64'(nt));
    chk("rx_free", 64'(rx_free), 64'(nr));
  endtask
  task automatic do_req(input bit d, input int per, input bit r, input bit rd, input int rc);
    bit ok, lg;
    int ch;
    chk("req_ready", 64'(req_ready), 64'(1));
    model_pick(d, per, ok, ch);
    req_valid = 1'b1; req_dir = d; req_per = PW'(per);
    rel_valid = r; rel_dir = rd; rel_ch = CW'(rc);
    @(posedge clk);
    lg = 0;
    if (r) model_rel(rd, rc, lg);
    if (ok) begin m_busy[d][ch] = 1; m_own[d][ch] = per; end
    @(negedge clk);
    req_valid = 1'b0; rel_valid = 1'b0;
    chk("gnt_valid", 64'(gnt_valid), 64'(1));
    chk("gnt_ok", 64'(gnt_ok), 64'(ok));
    chk("gnt_ch", 64'(gnt_ch), ok ? 64'(ch) : 64'(0));
    chk("rel_err_req", 64'(rel_err), 64'(r && !lg));
    check_state();
    gnt_ready = 1'b1;
    @(negedge clk);
    gnt_ready = 1'b0;
    chk("gnt_drop", 64'(gnt_valid), 64'(0));
  endtask
  task automatic do_rel(input bit d, input int c);
    bit lg;
    rel_valid = 1'b1; rel_dir = d; rel_ch = CW'(c);
    @(posedge clk);
    model_rel(d, c, lg);
    @(negedge clk);
    rel_valid = 1'b0;
    chk("rel_err", 64'(rel_err), 64'(!lg));
    check_state();
    @(negedge clk);
    chk("rel_err_pulse", 64'(rel_err), 64'(0));
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    chk({tag, "_gnt_valid"}, 64'(gnt_valid), 64'(0));
    chk({tag, "_gnt_ok"}, 64'(gnt_ok), 64'(0));
    chk({tag, "_gnt_ch"}, 64'(gnt_ch), 64'(0));
    chk({tag, "_rel_err"}, 64'(rel_err), 64'(0));
    check_state();
  endtask
  initial begin
    logic [CW-1:0] held;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rstn = 1'b1;
    @(negedge clk);
    do_req(0, 3, 0, 0, 0);
    do_req(0, 5, 0, 0, 0);
    do_req(0, 7, 0, 0, 0);
    chk("tx_busy_07", 64'(tx_busy), 64'h007);
    for (int i = 0; i < NR; i++) do_req(1, i + 1, 0, 0, 0);
    do_req(1, 10, 0, 0, 0);
    chk("rx_full_free", 64'(rx_free), 64'(0));
    do_rel(0, 1);
    do_req(0, 9, 0, 0, 0);
    do_rel(0, 1);
    do_rel(0, 1);
    do_rel(0, 12);
    do_rel(1, 12);
    do_req(1, 11, 1, 1, 4);
    chk("rx_free_one", 64'(rx_free), 64'(1));
    do_req(1, 12, 0, 0, 0);
    do_req(0, 2, 1, 1, 0);
    chk("req_ready_hold", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_dir = 1'b0; req_per = PW'(6);
    @(negedge clk);
    req_valid = 1'b0;
    held = gnt_ch;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(gnt_valid), 64'(1));
      chk("hold_ch", 64'(gnt_ch), 64'(held));
      chk("hold_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    #2 rstn = 1'b0;
    #1 model_reset();
    reset_checks("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_req(0, 2, 0, 0, 0);
    do_req(0, 4, 0, 0, 0);
    do_rel(0, 0);
    do_rel(0, 1);
    do_req(0, 4, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      bit d, rd;
      d  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) do_rel(rd, int'($urandom_range(0, 13)));
      else do_req(d, int'($urandom_range(0, NP - 1)), 1'($urandom_range(0, 1)), rd, int'($urandom_range(0, 13)));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
